debug_uart_tx_fifo: RTL and testbench
=====================================

Name: debug_uart_tx_fifo

Overview:
Buffered transmitter for the debug UART, driving uo_out[6] when GPIO output select bit 7:6 routes the debug UART. The write path comes from the debug UART peripheral address decode: a write strobe plus data_to_write[7:0]. A small FIFO decouples firmware writes from serialisation, so the core does not stall polling busy on every byte. The block serialises 8N1 frames, LSB first, and exposes busy/full/level status for the debug UART status register.

Parameters:
CLK_HZ, 64_000_000, system clock frequency in Hz
BIT_RATE, 4_000_000, serial bit rate in bits/s; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer, >=2; default 16)
DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries (default 4)

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  reset; synchronous, active-low
wr_en  input  1  write strobe; one byte pushed per cycle high
wr_data  input  8  byte to transmit, sampled when wr_en=1
clr_overflow  input  1  clears sticky overflow flag
uart_txd  output  1  serial line, idle high
busy  output  1  1 when the FIFO is non-empty or a frame is in progress
full  output  1  FIFO holds 2**DEPTH_LOG2 entries
level  output  DEPTH_LOG2+1  number of entries currently in the FIFO
overflow  output  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO pointers=0, level=0, full=0, overflow=0, FSM=IDLE, uart_txd=1, busy=0, bit and cycle counters=0. Reset mid-frame aborts the frame. uart_txd returns high on the reset edge. Queued bytes are discarded.
- FIFO: circular buffer with read and write pointers DEPTH_LOG2 bits wide, wrapping modulo depth. level is tracked explicitly.
- FIFO write: wr_en=1 and not full -> store the byte and increment level.
- FIFO full: wr_en=1 while full and no pop in the same cycle -> byte dropped, overflow<=1, level unchanged.
- Simultaneous push and pop: the push is accepted even when full, because the pop frees the slot. level is unchanged.
- overflow clear: clr_overflow=1 clears overflow. If clr_overflow and a dropped write occur in the same cycle, set wins.
- busy: combinational (FSM!=IDLE) | (level!=0).
- full: combinational (level==depth).
- FSM states IDLE, START, DATA, STOP. A cycle counter counts 0..CYCLES_PER_BIT-1; a 3-bit bit index is used in DATA.
  - IDLE: uart_txd=1. If level!=0, pop the head into a shift register and go to START (txd=0 from the next cycle). A byte written into an empty FIFO at edge N appears as txd=0 starting at edge N+1.
  - START: txd=0 for CYCLES_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CYCLES_PER_BIT cycles per bit, then shift right. After bit 7, go to STOP.
  - STOP: txd=1 for CYCLES_PER_BIT cycles. At the end, if level!=0, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length: exactly 10*CYCLES_PER_BIT cycles (160 at defaults). Back-to-back frames are contiguous.
- uart_txd is driven from a register (glitch-free).
- A byte is popped only at the IDLE->START or STOP->START transition. wr_en has no effect on the frame in progress.
- Counter widths: sized with $clog2(CYCLES_PER_BIT). No wrap beyond CYCLES_PER_BIT-1.

Test Plan:
- Reset then idle 200 cycles -> uart_txd=1, busy=0, level=0, full=0, overflow=0 throughout.
- Single write 0x55 at edge N -> txd low at N+1..N+16, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then stop high 16 cycles. busy=1 for 160 cycles; busy=0 at N+161.
- Write 0xA3, 0x0F, 0xFF, 0x00 on 4 consecutive cycles -> full never asserts (the first byte is popped at N+1, so level peaks at 3). Four contiguous frames decode as A3, 0F, FF, 00 with no idle gaps. Total busy = 640 cycles.
- Write 6 bytes on consecutive cycles -> the first is popped, the next four fill the FIFO (full=1), the 6th is dropped, overflow=1. Only 5 frames are transmitted. Pulse clr_overflow -> overflow=0.
- FIFO full and STOP->START pop in the same cycle as wr_en -> the byte is accepted, level stays at 4, overflow stays 0, and the byte is transmitted last in order.
- Assert rst_n=0 mid-DATA of frame 0x3C with 2 bytes queued -> next edge: txd=1, level=0, busy=0. No further frames are sent after release.

Source files
------------

// File: rtl/debug_uart_tx_fifo_if.sv
// Write strobe / status bundle between the debug UART register decode and the
// buffered transmitter.
interface debug_uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 2
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  clr_overflow;
  logic                  uart_txd;
  logic                  busy;
  logic                  full;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;

  modport master (
    output wr_en, wr_data, clr_overflow,
    input  uart_txd, busy, full, level, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow,
    output uart_txd, busy, full, level, overflow
  );
endinterface

// File: rtl/debug_uart_tx_fifo.sv
// Debug UART transmitter: small byte FIFO feeding an 8N1 LSB-first serialiser.
// States: IDLE line high, waiting | START start bit | DATA 8 data bits | STOP stop bit
module debug_uart_tx_fifo #(
  parameter int CLK_HZ     = 64_000_000,
  parameter int BIT_RATE   = 4_000_000,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  debug_uart_tx_fifo_if.slave bus_if
);

  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  ovf_q, ovf_d;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  push, pop, drop, full, bit_end, has_data;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign has_data = (level_q != '0);
  assign bit_end  = (cnt_q == CNT_W'(CPB - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    pop      = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        cnt_d = '0;
        if (has_data) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // chain straight into the next start bit so frames stay contiguous
          if (has_data) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        cnt_d   = '0;
      end
    endcase

    // a pop in the same cycle frees the slot, so a write to a full FIFO still lands
    push = bus_if.wr_en && (!full || pop);
    drop = bus_if.wr_en && full && !pop;

    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop)                     ovf_d = 1'b1;
    else if (bus_if.clr_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus_if.wr_data;
  end

  assign bus_if.uart_txd = txd_q;
  assign bus_if.busy     = (state_q != IDLE) || has_data;
  assign bus_if.full     = full;
  assign bus_if.level    = level_q;
  assign bus_if.overflow = ovf_q;

endmodule

// File: tb/tb_debug_uart_tx_fifo.sv
// Directed bench for debug_uart_tx_fifo: drives writes, decodes the serial line
// independently and compares against hand-computed frames and status.
module tb_debug_uart_tx_fifo;

  localparam int CPB = 16;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  debug_uart_tx_fifo_if #(.DEPTH_LOG2(2)) bus ();

  debug_uart_tx_fifo #(
    .CLK_HZ(64_000_000), .BIT_RATE(4_000_000), .DEPTH_LOG2(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // line decoder, sampling mid-bit on the falling edge
  logic [7:0] rx_q [$];
  int         rx_start [$];
  int         cyc;
  int         mon_cnt;
  bit         mon_active;
  logic [7:0] mon_byte;
  int         frame_err;

  initial begin
    cyc = 0; mon_cnt = 0; mon_active = 0; mon_byte = 0; frame_err = 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (bus.uart_txd == 1'b0) begin
        mon_active = 1;
        mon_cnt    = 0;
        rx_start.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2 && bus.uart_txd !== 1'b0) frame_err++;
      if (mon_cnt >= CPB + CPB / 2 && mon_cnt < 9 * CPB && ((mon_cnt - CPB - CPB / 2) % CPB) == 0)
        mon_byte[(mon_cnt - CPB - CPB / 2) / CPB] = bus.uart_txd;
      if (mon_cnt == 9 * CPB + CPB / 2) begin
        if (bus.uart_txd !== 1'b1) frame_err++;
        rx_q.push_back(mon_byte);
      end
      if (mon_cnt == 10 * CPB - 1) mon_active = 0;
    end
  end

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (bus.busy && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq(tag, bus.busy, 1'b0);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_start.delete();
    frame_err = 0;
  endtask

  logic [7:0] v3 [4] = '{8'hA3, 8'h0F, 8'hFF, 8'h00};
  logic [7:0] v5 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h5A};

  initial begin
    logic [7:0] b;
    logic       e;
    int         busy_cnt, n, max_lvl, full_seen, low_cnt;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_overflow = 1'b0;

    // reset and idle
    tick(); tick();
    rst_n = 1'b1;
    check_eq("rst_txd", bus.uart_txd, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_level", bus.level, 3'd0);
    check_eq("rst_full", bus.full, 1'b0);
    check_eq("rst_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < 200; i++) begin
      tick();
      check_eq($sformatf("idle_c%0d", i),
               {bus.uart_txd, bus.busy, bus.level, bus.full, bus.overflow}, {1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    end

    // single byte 0x55
    clear_rx();
    b = 8'h55;
    bus.wr_en = 1'b1; bus.wr_data = b;
    tick();
    bus.wr_en = 1'b0;
    check_eq("t2_busy_n", bus.busy, 1'b1);
    check_eq("t2_level_n", bus.level, 3'd1);
    check_eq("t2_txd_n", bus.uart_txd, 1'b1);
    for (int c = 1; c <= 160; c++) begin
      tick();
      if (c <= 16)       e = 1'b0;
      else if (c <= 144) e = b[(c - 17) / 16];
      else               e = 1'b1;
      check_eq($sformatf("t2_txd_c%0d", c), bus.uart_txd, e);
      check_eq($sformatf("t2_busy_c%0d", c), bus.busy, 1'b1);
    end
    tick();
    check_eq("t2_busy_end", bus.busy, 1'b0);
    check_eq("t2_txd_end", bus.uart_txd, 1'b1);
    check_eq("t2_nframes", rx_q.size(), 1);
    if (rx_q.size() >= 1) check_eq("t2_byte", rx_q[0], 8'h55);

    // four back-to-back bytes
    clear_rx();
    busy_cnt = 0; max_lvl = 0; full_seen = 0;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = v3[i];
      tick();
      if (i > 0 && bus.busy) busy_cnt++;
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
      if (bus.full) full_seen++;
    end
    bus.wr_en = 1'b0;
    n = 0;
    while (bus.busy && n < 1000) begin
      tick();
      n++;
      if (bus.busy) busy_cnt++;
      if (bus.full) full_seen++;
    end
    check_eq("t3_idle", bus.busy, 1'b0);
    check_eq("t3_max_level", max_lvl, 3);
    check_eq("t3_full_seen", full_seen, 0);
    check_eq("t3_busy_cycles", busy_cnt, 640);
    check_eq("t3_nframes", rx_q.size(), 4);
    check_eq("t3_frame_err", frame_err, 0);
    if (rx_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check_eq($sformatf("t3_byte%0d", i), rx_q[i], v3[i]);
      for (int i = 1; i < 4; i++) check_eq($sformatf("t3_gap%0d", i), rx_start[i] - rx_start[i-1], 160);
    end

    // six bytes: one dropped
    clear_rx();
    bus.wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_data = 8'(i + 1);
      tick();
      if (i == 4) begin
        check_eq("t4_full", bus.full, 1'b1);
        check_eq("t4_level4", bus.level, 3'd4);
        check_eq("t4_ovf_pre", bus.overflow, 1'b0);
      end
    end
    bus.wr_en = 1'b0;
    check_eq("t4_ovf_set", bus.overflow, 1'b1);
    check_eq("t4_level_drop", bus.level, 3'd4);
    tick(); tick();
    check_eq("t4_ovf_sticky", bus.overflow, 1'b1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check_eq("t4_ovf_clr", bus.overflow, 1'b0);
    wait_idle("t4_idle", 2000);
    check_eq("t4_nframes", rx_q.size(), 5);
    check_eq("t4_frame_err", frame_err, 0);
    if (rx_q.size() == 5)
      for (int i = 0; i < 5; i++) check_eq($sformatf("t4_byte%0d", i), rx_q[i], 8'(i + 1));

    // write into full FIFO on the STOP->START pop edge
    clear_rx();
    bus.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = v5[i];
      tick();
    end
    bus.wr_en = 1'b0;
    check_eq("t5_full", bus.full, 1'b1);
    for (int i = 0; i < 156; i++) tick();
    check_eq("t5_level_pre", bus.level, 3'd4);
    check_eq("t5_txd_stop", bus.uart_txd, 1'b1);
    bus.wr_en = 1'b1; bus.wr_data = v5[5];
    tick();
    bus.wr_en = 1'b0;
    check_eq("t5_level_post", bus.level, 3'd4);
    check_eq("t5_ovf", bus.overflow, 1'b0);
    check_eq("t5_txd_start", bus.uart_txd, 1'b0);
    wait_idle("t5_idle", 2000);
    check_eq("t5_nframes", rx_q.size(), 6);
    check_eq("t5_frame_err", frame_err, 0);
    if (rx_q.size() == 6)
      for (int i = 0; i < 6; i++) check_eq($sformatf("t5_byte%0d", i), rx_q[i], v5[i]);
    if (rx_start.size() == 6) check_eq("t5_gap", rx_start[5] - rx_start[4], 160);

    // reset mid-DATA with two bytes queued
    clear_rx();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h3C; tick();
    bus.wr_data = 8'h81; tick();
    bus.wr_data = 8'h7E; tick();
    bus.wr_en = 1'b0;
    check_eq("t6_level", bus.level, 3'd2);
    for (int i = 0; i < 58; i++) tick();
    check_eq("t6_busy_pre", bus.busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check_eq("t6_txd", bus.uart_txd, 1'b1);
    check_eq("t6_level_rst", bus.level, 3'd0);
    check_eq("t6_busy_rst", bus.busy, 1'b0);
    check_eq("t6_full_rst", bus.full, 1'b0);
    rst_n = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.uart_txd !== 1'b1 || bus.busy !== 1'b0) low_cnt++;
    end
    check_eq("t6_quiet", low_cnt, 0);
    check_eq("t6_nframes", rx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
